// File: rtl/chunk_frame_buffer_pkg.sv
// Shared geometry, FSM encoding and helpers for the chunk frame buffer.
// Bank count depends on DOUBLE_BUFFER_EN (defined: two banks, undefined: one bank).
package chunk_frame_buffer_pkg;

  localparam int DATA_W       = 32;
  localparam int PANEL_W      = 2;
  localparam int ROW_W        = 4;
  localparam int CHUNK_W      = 4;
  localparam int FRAME_ADDR_W = PANEL_W + ROW_W + CHUNK_W;
  localparam int FCOUNT_W     = 8;

  localparam logic [PANEL_W-1:0] LAST_PANEL = '1;
  localparam logic [ROW_W-1:0]   LAST_ROW   = '1;
  localparam logic [CHUNK_W-1:0] LAST_CHUNK = '1;

`ifdef DOUBLE_BUFFER_EN
  localparam int BANK_W = 1;
`else
  localparam int BANK_W = 0;
`endif
  localparam int RAM_ADDR_W = FRAME_ADDR_W + BANK_W;

  typedef enum logic {
    ST_FILL    = 1'b0,
    ST_PENDING = 1'b1
  } fsm_state_t;

  // The final chunk of panel 3 / row 15 doubles as the end-of-frame marker.
  function automatic logic is_last_addr(input logic [PANEL_W-1:0] panel,
                                        input logic [ROW_W-1:0]   row,
                                        input logic [CHUNK_W-1:0] chunk);
    return (panel == LAST_PANEL) && (row == LAST_ROW) && (chunk == LAST_CHUNK);
  endfunction

endpackage

// File: rtl/chunk_frame_buffer_if.sv
// Chunk write bus (from the USB controller) and scan read bus (from the cube driver).
// The master side drives requests; the slave side is the frame buffer.
interface chunk_frame_buffer_if;
  import chunk_frame_buffer_pkg::*;

  logic [DATA_W-1:0]       chunk_data;
  logic [CHUNK_W-1:0]      chunk_addr;
  logic [ROW_W-1:0]        row_addr;
  logic [PANEL_W-1:0]      panel_addr;
  logic                    chunk_write_enable;
  logic                    rd_start;
  logic                    rd_en;
  logic [FRAME_ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0]       rd_data;
  logic                    rd_valid;

  modport master (
    output chunk_data, chunk_addr, row_addr, panel_addr, chunk_write_enable,
    output rd_start, rd_en, rd_addr,
    input  rd_data, rd_valid
  );

  modport slave (
    input  chunk_data, chunk_addr, row_addr, panel_addr, chunk_write_enable,
    input  rd_start, rd_en, rd_addr,
    output rd_data, rd_valid
  );

endinterface

// File: rtl/chunk_frame_buffer_ram.sv
// Simple dual-port RAM: one write port, one registered read port, read-before-write.
// No reset so it maps onto block RAM; contents survive a logic reset.
module chunk_frame_buffer_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  // Read output only updates on a request, so it holds the last word otherwise.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/chunk_frame_buffer.sv
// Chunk frame buffer: captures USB chunks into the back bank, scan-out reads the front bank,
// banks swap on rd_start once a full frame has landed. DOUBLE_BUFFER_EN selects two banks.
module chunk_frame_buffer
  import chunk_frame_buffer_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  chunk_frame_buffer_if.slave bus,
  output logic                o_display_bank,
  output logic                o_swap_pending,
  output logic                o_overrun,
  output logic [FCOUNT_W-1:0] o_frame_count
);

  fsm_state_t          r_state;
  logic                r_display_bank;
  logic                r_swap_pending;
  logic                r_overrun;
  logic [FCOUNT_W-1:0] r_frame_count;
  logic                r_rd_valid;
  logic                r_rd_primed;

  logic                    w_eof_write;
  logic [FRAME_ADDR_W-1:0] w_frame_waddr;
  logic [RAM_ADDR_W-1:0]   w_ram_waddr;
  logic [RAM_ADDR_W-1:0]   w_ram_raddr;
  logic [DATA_W-1:0]       w_ram_rdata;

  assign w_frame_waddr = {bus.panel_addr, bus.row_addr, bus.chunk_addr};
  assign w_eof_write   = bus.chunk_write_enable &&
                         is_last_addr(bus.panel_addr, bus.row_addr, bus.chunk_addr);

  // Bank is picked from the current display_bank, so a read issued in a swap cycle
  // still comes from the bank that was front when it was issued.
`ifdef DOUBLE_BUFFER_EN
  assign w_ram_waddr = {~r_display_bank, w_frame_waddr};
  assign w_ram_raddr = {r_display_bank, bus.rd_addr};
`else
  assign w_ram_waddr = w_frame_waddr;
  assign w_ram_raddr = bus.rd_addr;
`endif

  chunk_frame_buffer_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (RAM_ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (bus.chunk_write_enable),
    .i_waddr (w_ram_waddr),
    .i_wdata (bus.chunk_data),
    .i_re    (bus.rd_en),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_FILL;
      r_display_bank <= 1'b0;
      r_swap_pending <= 1'b0;
      r_overrun      <= 1'b0;
      r_frame_count  <= '0;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_eof_write) begin
            r_state        <= ST_PENDING;
            r_swap_pending <= 1'b1;
          end
        end
        ST_PENDING: begin
          if (w_eof_write) r_overrun <= 1'b1;
          if (bus.rd_start) begin
            r_state        <= ST_FILL;
            r_swap_pending <= 1'b0;
            r_frame_count  <= r_frame_count + FCOUNT_W'(1);
`ifdef DOUBLE_BUFFER_EN
            r_display_bank <= ~r_display_bank;
`endif
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

  // RAM output has no reset; r_rd_primed masks it to zero until the first read after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid  <= 1'b0;
      r_rd_primed <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_en;
      if (bus.rd_en) r_rd_primed <= 1'b1;
    end
  end

  assign bus.rd_data     = r_rd_primed ? w_ram_rdata : '0;
  assign bus.rd_valid    = r_rd_valid;
  assign o_display_bank  = r_display_bank;
  assign o_swap_pending  = r_swap_pending;
  assign o_overrun       = r_overrun;
  assign o_frame_count   = r_frame_count;

endmodule

// File: tb/tb_chunk_frame_buffer.sv
// Self-checking bench for chunk_frame_buffer: directed scenarios plus random traffic
// compared every cycle against a bank/frame-level reference model.
`timescale 1ns/1ps
module tb_chunk_frame_buffer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       disp, sp, ov;
  logic [7:0] fc;

  always #10 clk = ~clk;

  chunk_frame_buffer_if bus();

  chunk_frame_buffer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .o_display_bank (disp),
    .o_swap_pending (sp),
    .o_overrun      (ov),
    .o_frame_count  (fc)
  );

`ifdef DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: physical banks, front bank, pending/overrun flags, swap count.
  logic [31:0] m_mem   [2][1024];
  bit          m_known [2][1024];
  bit          m_front, m_pending, m_overrun;
  int          m_swaps;
  bit          m_valid, m_data_known;
  logic [31:0] m_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_front = 0; m_pending = 0; m_overrun = 0; m_swaps = 0;
    m_valid = 0; m_data = 32'h0; m_data_known = 1;
  endtask

  task automatic model_step();
    int  rb, wb, wa;
    bit  pend_old;
    rb = DB ? int'(m_front) : 0;
    wb = DB ? int'(!m_front) : 0;
    wa = int'({bus.panel_addr, bus.row_addr, bus.chunk_addr});
    if (bus.rd_en) begin
      m_valid      = 1;
      m_data_known = m_known[rb][bus.rd_addr];
      m_data       = m_mem[rb][bus.rd_addr];
    end else begin
      m_valid = 0;
    end
    if (bus.chunk_write_enable) begin
      m_mem[wb][wa]   = bus.chunk_data;
      m_known[wb][wa] = 1;
    end
    pend_old = m_pending;
    if (bus.chunk_write_enable && wa == 1023) begin
      if (pend_old) m_overrun = 1;
      else          m_pending = 1;
    end
    if (pend_old && bus.rd_start) begin
      m_pending = 0;
      m_swaps++;
      if (DB) m_front = !m_front;
      $display("swap %0d: front bank %0d overrun %0d", m_swaps, m_front, m_overrun);
    end
  endtask

  task automatic check_all();
    check("rd_valid", 32'(bus.rd_valid), 32'(m_valid));
    if (m_data_known) check("rd_data", bus.rd_data, m_data);
    check("display_bank", 32'(disp), 32'(m_front));
    check("swap_pending", 32'(sp), 32'(m_pending));
    check("overrun", 32'(ov), 32'(m_overrun));
    check("frame_count", 32'(fc), 32'(m_swaps % 256));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input bit we, input logic [9:0] wa, input logic [31:0] wd,
                       input bit rs, input bit re, input logic [9:0] ra);
    bus.chunk_write_enable = we;
    {bus.panel_addr, bus.row_addr, bus.chunk_addr} = wa;
    bus.chunk_data = wd;
    bus.rd_start   = rs;
    bus.rd_en      = re;
    bus.rd_addr    = ra;
    tick();
  endtask

  task automatic idle();
    drive(0, 10'h0, 32'h0, 0, 0, 10'h0);
  endtask

  initial begin
    logic [9:0]  wa, ra;
    logic [31:0] wd;
    bus.chunk_write_enable = 0; bus.chunk_data = 0; bus.chunk_addr = 0;
    bus.row_addr = 0; bus.panel_addr = 0; bus.rd_start = 0; bus.rd_en = 0; bus.rd_addr = 0;
    model_reset();

    // Reset values
    repeat (2) tick();
    #3 rst_n = 1'b1;

    // Full frame with data = address, then swap and burst-read it back
    for (int a = 0; a < 1024; a++) drive(1, 10'(a), 32'(a), 0, 0, 10'h0);
    idle();
    drive(0, 10'h0, 32'h0, 1, 0, 10'h0);
    for (int a = 0; a < 1024; a++) drive(0, 10'h0, 32'h0, 0, 1, 10'(a));
    idle();

    // Read front addr 5 while writing back addr 5, then swap and read it again
    drive(1, 10'd5, 32'h12345678, 0, 1, 10'd5);
    drive(1, 10'h3FF, 32'hCAFEF00D, 0, 0, 10'h0);
    drive(0, 10'h0, 32'h0, 1, 0, 10'h0);
    drive(0, 10'h0, 32'h0, 0, 1, 10'd5);
    idle();

    // Two frames completed without rd_start -> overrun; one rd_start -> one swap
    drive(1, 10'h3FF, 32'h11111111, 0, 0, 10'h0);
    drive(1, 10'h3FF, 32'h22222222, 0, 0, 10'h0);
    idle();
    drive(0, 10'h0, 32'h0, 1, 0, 10'h0);
    drive(0, 10'h0, 32'h0, 1, 0, 10'h0);
    idle();

    // Same-cycle end-of-frame write and rd_start in FILL
    drive(1, 10'h3FF, 32'h33333333, 1, 0, 10'h0);
    idle();
    drive(0, 10'h0, 32'h0, 1, 1, 10'h3FF);
    idle();

    // Enough swaps to wrap frame_count
    for (int i = 0; i < 260; i++) begin
      drive(1, 10'h3FF, $urandom, 0, 0, 10'h0);
      drive(0, 10'h0, 32'h0, 1, 0, 10'h0);
    end

    // Random traffic with a reset mid-frame during an outstanding read
    for (int i = 0; i < 4000; i++) begin
      wa = ($urandom_range(0, 15) == 0) ? 10'h3FF : 10'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? wa : 10'($urandom);
      wd = $urandom;
      drive($urandom_range(0, 2) != 0, wa, wd, $urandom_range(0, 7) == 0,
            $urandom_range(0, 1) == 1, ra);
      if (i == 2000) begin
        drive(1, 10'd100, 32'hA5A5A5A5, 0, 1, 10'd7);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        bus.chunk_write_enable = 0;
        bus.rd_en = 1;
        bus.rd_start = 0;
        tick();
        #3 rst_n = 1'b1;
      end
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
